// File: rtl/artyz7_led_sequencer_pkg.sv
// Shared types and constants for the Arty Z7 LED sequencer.
package artyz7_led_sequencer_pkg;

  localparam int unsigned mode_width = 2;
  localparam int unsigned num_leds   = 4;

  typedef enum logic [mode_width-1:0] {
    MODE_OFF,
    MODE_STATIC,
    MODE_BLINK,
    MODE_CHASE
  } led_mode_t;

endpackage

// File: rtl/led_tick_prescaler.sv
// Free-running step prescaler: pulses step_strobe once every TICK_DIVIDER cycles.
module led_tick_prescaler #(
  parameter int unsigned TICK_DIVIDER = 12500000
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic step_strobe
);

  localparam int unsigned CntW = $clog2(TICK_DIVIDER);
  localparam logic [CntW-1:0] Last = CntW'(TICK_DIVIDER - 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset || restart) begin
      cnt_q <= '0;
    end else if (cnt_q == Last) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign step_strobe = (cnt_q == Last);

endmodule

// File: rtl/artyz7_led_sequencer.sv
// LED sequencer top: command handshake, OFF/STATIC/BLINK/CHASE mode FSM and LED register.
// Optional PWM brightness gating is enabled by defining ARTYZ7_LED_SEQUENCER_PWM_EN.
module artyz7_led_sequencer
  import artyz7_led_sequencer_pkg::*;
#(
  parameter int unsigned NUM_LEDS     = num_leds,
  parameter int unsigned TICK_DIVIDER = 12500000,
  parameter int unsigned PWM_BITS     = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [mode_width-1:0] cfg_mode,
  input  logic [NUM_LEDS-1:0]   cfg_pattern,
  input  logic [PWM_BITS-1:0]   cfg_brightness,
  output logic                  step_strobe,
  output logic [NUM_LEDS-1:0]   leds
);

  led_mode_t           mode_q, mode_d;
  logic                ready_q, apply_q;
  logic [NUM_LEDS-1:0] pattern_q;
  logic [NUM_LEDS-1:0] seq_q, seq_d;
  logic                accept;

  assign accept    = cfg_valid & ready_q;
  assign cfg_ready = ready_q;

  led_tick_prescaler #(
    .TICK_DIVIDER (TICK_DIVIDER)
  ) u_prescaler (
    .clk         (clk),
    .reset       (reset),
    .restart     (accept),
    .step_strobe (step_strobe)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q <= MODE_OFF;
    end else begin
      mode_q <= mode_d;
    end
  end

  always_comb begin
    mode_d = mode_q;
    if (accept) begin
      mode_d = led_mode_t'(cfg_mode);
    end
  end

  // A step coinciding with an accept is dropped; the prescaler restarts instead.
  always_comb begin
    seq_d = seq_q;
    if (apply_q) begin
      seq_d = (mode_q == MODE_OFF) ? '0 : pattern_q;
    end else if (step_strobe && !accept) begin
      unique case (mode_q)
        MODE_OFF:    seq_d = '0;
        MODE_STATIC: seq_d = pattern_q;
        MODE_BLINK:  seq_d = (seq_q == '0) ? pattern_q : '0;
        MODE_CHASE:  seq_d = {seq_q[NUM_LEDS-2:0], seq_q[NUM_LEDS-1]};
        default:     seq_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q   <= 1'b0;
      apply_q   <= 1'b0;
      pattern_q <= '0;
      seq_q     <= '0;
    end else begin
      ready_q <= ~accept;
      apply_q <= accept;
      if (accept) begin
        pattern_q <= cfg_pattern;
      end
      seq_q <= seq_d;
    end
  end

`ifdef ARTYZ7_LED_SEQUENCER_PWM_EN
  logic [PWM_BITS-1:0] pwm_cnt_q, brightness_q;
  logic [NUM_LEDS-1:0] leds_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt_q    <= '0;
      brightness_q <= '0;
      leds_q       <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + 1'b1;
      if (accept) begin
        brightness_q <= cfg_brightness;
      end
      leds_q <= seq_q & {NUM_LEDS{pwm_cnt_q < brightness_q}};
    end
  end

  assign leds = leds_q;
`else
  logic unused_brightness;
  assign unused_brightness = ^cfg_brightness;
  assign leds = seq_q;
`endif

endmodule

// File: tb/tb_artyz7_led_sequencer.sv
// Self-checking bench for artyz7_led_sequencer with a step-count based reference model.
module tb_artyz7_led_sequencer;
  import artyz7_led_sequencer_pkg::*;

  localparam int unsigned N   = 4;
  localparam int unsigned DIV = 4;
  localparam int unsigned PB  = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cfg_valid = 1'b0;
  logic [1:0]    cfg_mode = 2'd0;
  logic [N-1:0]  cfg_pattern = '0;
  logic [PB-1:0] cfg_brightness = '0;
  wire           cfg_ready;
  wire           step_strobe;
  wire  [N-1:0]  leds;

  always #5 clk = ~clk;

  artyz7_led_sequencer #(
    .NUM_LEDS     (N),
    .TICK_DIVIDER (DIV),
    .PWM_BITS     (PB)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .cfg_valid      (cfg_valid),
    .cfg_ready      (cfg_ready),
    .cfg_mode       (cfg_mode),
    .cfg_pattern    (cfg_pattern),
    .cfg_brightness (cfg_brightness),
    .step_strobe    (step_strobe),
    .leds           (leds)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: LED value is a function of mode, pattern and steps since apply.
  int           m_cnt = 0;
  int           m_mode = 0;
  int           m_steps = 0;
  bit           m_ready = 1'b0;
  bit           m_apply = 1'b0;
  logic [N-1:0] m_pat = '0;
  logic [N-1:0] m_leds = '0;

  function automatic logic [N-1:0] seq_value(input int mode, input logic [N-1:0] pat,
                                             input int k);
    int s;
    s = k % N;
    case (mode)
      0:       return '0;
      1:       return pat;
      2:       return (k % 2 == 0) ? pat : '0;
      default: return (pat << s) | (pat >> (N - s));
    endcase
  endfunction

  task automatic cyc();
    bit acc, strobe;
    if (reset) begin
      m_cnt = 0; m_mode = 0; m_steps = 0; m_ready = 0; m_apply = 0; m_pat = '0; m_leds = '0;
    end else begin
      acc    = cfg_valid && m_ready;
      strobe = (m_cnt == DIV - 1);
      if (m_apply) begin
        m_steps = 0;
        m_leds  = seq_value(m_mode, m_pat, 0);
      end else if (strobe && !acc) begin
        m_steps++;
        m_leds = seq_value(m_mode, m_pat, m_steps);
      end
      if (acc) begin
        m_mode = int'(cfg_mode); m_pat = cfg_pattern;
        m_cnt = 0; m_apply = 1; m_ready = 0;
      end else begin
        m_apply = 0; m_ready = 1;
        m_cnt = strobe ? 0 : m_cnt + 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] md, input logic [N-1:0] p, input logic [PB-1:0] b);
    bit done = 0;
    cfg_valid = 1; cfg_mode = md; cfg_pattern = p; cfg_brightness = b;
    for (int i = 0; i < 10 && !done; i++) begin
      if (cfg_ready === 1'b1) done = 1;
      cyc();
    end
    cfg_valid = 0;
    checks++;
    if (!done) begin failures++; $display("FAIL send_timeout mode=%0d no cfg_ready", md); end
  endtask

  task automatic wait_strobe();
    bit seen = 0;
    for (int i = 0; i < 2 * DIV && !seen; i++) begin
      if (step_strobe === 1'b1) seen = 1;
      else cyc();
    end
    seen = seen || (step_strobe === 1'b1);
    checks++;
    if (!seen) begin failures++; $display("FAIL strobe_timeout no step_strobe seen"); end
  endtask

  task automatic test_reset();
    int n = 0;
    reset = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if (leds !== 4'b0000 || cfg_ready !== 1'b0 || step_strobe !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold leds=%b ready=%b strobe=%b want 0000/0/0",
                 leds, cfg_ready, step_strobe);
      end
    end
    reset = 0;
    cyc();
    checks++;
    if (cfg_ready !== 1'b1 || leds !== 4'b0000) begin
      failures++; $display("FAIL reset_release ready=%b leds=%b want 1/0000", cfg_ready, leds);
    end
    for (int i = 0; i < 8; i++) begin
      if (step_strobe === 1'b1) n++;
      cyc();
    end
    checks++;
    if (n != 2) begin failures++; $display("FAIL strobe_rate got=%0d want=2 in 8 cycles", n); end
  endtask

  task automatic test_static();
    send(2'd1, 4'b1010, '0);
    checks++;
    if (cfg_ready !== 1'b0 || leds !== 4'b0000) begin
      failures++; $display("FAIL static_apply ready=%b leds=%b want 0/0000", cfg_ready, leds);
    end
    cyc();
    checks++;
    if (cfg_ready !== 1'b1 || leds !== 4'b1010) begin
      failures++; $display("FAIL static_first ready=%b leds=%b want 1/1010", cfg_ready, leds);
    end
    for (int i = 0; i < 5; i++) begin
      wait_strobe();
      cyc();
      checks++;
      if (leds !== 4'b1010) begin
        failures++; $display("FAIL static_hold step=%0d leds=%b want 1010", i, leds);
      end
    end
  endtask

  task automatic test_chase();
    logic [N-1:0] exp_seq [4];
    exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    send(2'd3, 4'b1000, '0);
    cyc();
    checks++;
    if (leds !== 4'b1000) begin failures++; $display("FAIL chase_first leds=%b want 1000", leds); end
    for (int i = 0; i < 4; i++) begin
      wait_strobe();
      cyc();
      checks++;
      if (leds !== exp_seq[i]) begin
        failures++; $display("FAIL chase_step%0d leds=%b want %b", i, leds, exp_seq[i]);
      end
    end
  endtask

  task automatic test_blink_off();
    send(2'd2, 4'b0110, '0);
    cyc();
    checks++;
    if (leds !== 4'b0110) begin failures++; $display("FAIL blink_first leds=%b want 0110", leds); end
    wait_strobe(); cyc();
    checks++;
    if (leds !== 4'b0000) begin failures++; $display("FAIL blink_off_phase leds=%b want 0000", leds); end
    wait_strobe(); cyc();
    checks++;
    if (leds !== 4'b0110) begin failures++; $display("FAIL blink_on_phase leds=%b want 0110", leds); end
    wait_strobe();
    send(2'd0, 4'b1111, '0);
    checks++;
    if (leds !== 4'b0110 || cfg_ready !== 1'b0) begin
      failures++; $display("FAIL off_step_drop leds=%b ready=%b want 0110/0", leds, cfg_ready);
    end
    cyc();
    checks++;
    if (leds !== 4'b0000 || step_strobe !== 1'b0) begin
      failures++; $display("FAIL off_apply leds=%b strobe=%b want 0000/0", leds, step_strobe);
    end
    cyc();
    checks++;
    if (step_strobe !== 1'b0) begin failures++; $display("FAIL off_restart_early strobe=1 want 0"); end
    cyc();
    checks++;
    if (step_strobe !== 1'b1) begin failures++; $display("FAIL off_restart_strobe strobe=0 want 1"); end
  endtask

  task automatic test_back_to_back();
    cfg_valid = 1; cfg_mode = 2'd1; cfg_pattern = 4'b0011;
    checks++;
    if (cfg_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_pre ready=0 want 1"); end
    cyc();
    checks++;
    if (cfg_ready !== 1'b0) begin failures++; $display("FAIL b2b_accept1 ready=1 want 0"); end
    cfg_mode = 2'd3; cfg_pattern = 4'b0101;
    cyc();
    checks++;
    if (cfg_ready !== 1'b1 || leds !== 4'b0011) begin
      failures++; $display("FAIL b2b_apply1 ready=%b leds=%b want 1/0011", cfg_ready, leds);
    end
    cyc();
    checks++;
    if (cfg_ready !== 1'b0 || leds !== 4'b0011) begin
      failures++; $display("FAIL b2b_accept2 ready=%b leds=%b want 0/0011", cfg_ready, leds);
    end
    cfg_valid = 0;
    cyc();
    checks++;
    if (cfg_ready !== 1'b1 || leds !== 4'b0101) begin
      failures++; $display("FAIL b2b_apply2 ready=%b leds=%b want 1/0101", cfg_ready, leds);
    end
  endtask

  task automatic test_reset_mid();
    wait_strobe(); cyc();
    checks++;
    if (leds !== 4'b1010) begin failures++; $display("FAIL mid_chase leds=%b want 1010", leds); end
    reset = 1;
    cyc();
    checks++;
    if (leds !== 4'b0000 || cfg_ready !== 1'b0 || step_strobe !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset leds=%b ready=%b strobe=%b want 0000/0/0", leds, cfg_ready, step_strobe);
    end
    reset = 0;
    cyc();
    checks++;
    if (cfg_ready !== 1'b1 || leds !== 4'b0000) begin
      failures++; $display("FAIL mid_release ready=%b leds=%b want 1/0000", cfg_ready, leds);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      reset       = ($urandom_range(0, 63) == 0);
      cfg_valid   = ($urandom_range(0, 5) == 0);
      cfg_mode    = 2'($urandom_range(0, 3));
      cfg_pattern = N'($urandom);
      cyc();
      checks++;
      if (leds !== m_leds) begin
        failures++; $display("FAIL rand_leds i=%0d got=%b want=%b", i, leds, m_leds);
      end
      checks++;
      if (cfg_ready !== m_ready) begin
        failures++; $display("FAIL rand_ready i=%0d got=%b want=%b", i, cfg_ready, m_ready);
      end
      checks++;
      if (step_strobe !== (m_cnt == DIV - 1)) begin
        failures++; $display("FAIL rand_strobe i=%0d got=%b want=%b", i, step_strobe,
                             (m_cnt == DIV - 1));
      end
    end
    reset = 0; cfg_valid = 0;
  endtask

`ifdef ARTYZ7_LED_SEQUENCER_PWM_EN
  task automatic test_pwm();
    int levels [3];
    int lit, bad;
    levels = '{4, 0, 15};
    for (int j = 0; j < 3; j++) begin
      send(2'd1, 4'b1111, PB'(levels[j]));
      repeat (4) cyc();
      lit = 0; bad = 0;
      for (int i = 0; i < 16; i++) begin
        if (leds === 4'b1111) lit++;
        else if (leds !== 4'b0000) bad++;
        cyc();
      end
      checks++;
      if (lit != levels[j] || bad != 0) begin
        failures++;
        $display("FAIL pwm_duty b=%0d lit=%0d bad=%0d want lit=%0d bad=0", levels[j], lit, bad,
                 levels[j]);
      end
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
`ifdef ARTYZ7_LED_SEQUENCER_PWM_EN
    test_pwm();
`else
    test_static();
    test_chase();
    test_blink_off();
    test_back_to_back();
    test_reset_mid();
    test_random();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
